movement_executor: RTL and testbench
====================================

Name: movement_executor

Overview:
- Consumes the 4-bit movement codes issued by the maze-navigation FSM.
- Turns each absolute-direction code into timed differential-drive motor commands: rotate from the current heading to the target heading, then advance one cell.
- Tracks the robot heading, and acknowledges each command with a valid/ready handshake and a completion pulse.
- Sits between the navigation FSM and the wheel driver stage.

Parameters:
- TURN90_CYCLES, 1000: clock cycles that motors run for one 90-degree in-place rotation (>=1).
- STEP_CYCLES, 4000: clock cycles that motors run forward for one cell advance (>=1).
- SETTLE_CYCLES, 100: motors-off dwell after every rotation and after the step (>=1).
- CNT_W, 16: duration counter width; each cycle parameter must fit in CNT_W bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd  in  4  movement code.
- cmd_valid  in  1  cmd is valid.
- cmd_ready  out  1  block can accept a command.
- stop  in  1  synchronous abort of the command in progress.
- motor_l_en  out  1  left wheel enable.
- motor_l_dir  out  1  left wheel direction (1=forward, 0=reverse).
- motor_r_en  out  1  right wheel enable.
- motor_r_dir  out  1  right wheel direction (1=forward, 0=reverse).
- heading  out  2  current heading (0..3).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle pulse: an unrecognised code was accepted.

Behaviour:
- Reset (async, any state):
  - state=IDLE, heading=0, counter=0.
  - All motor outputs 0, busy=0, done=0, cmd_err=0, cmd_ready=1.
  - Motors stop immediately, including mid-turn or mid-step.
- Code map (target heading):
  - 4'b0001 -> 0; 4'b0011 -> 1; 4'b0010 -> 2; 4'b0100 -> 3.
  - 4'b0000 = no-op.
  - All other codes are invalid.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - Accept happens on the rising edge where cmd_valid & cmd_ready; cmd is captured on that edge.
  - cmd_valid while busy is ignored; the command is not lost, and it is accepted once back in IDLE.
  - No queueing.
- Rotation delta = (target - heading) mod 4, unsigned 2-bit wrap:
  - delta 0: no turn.
  - delta 1: one right turn.
  - delta 2: two right turns.
  - delta 3: one left turn.
- States:
  - IDLE.
  - TURN: right turn = L en/fwd, R en/rev; left turn = L en/rev, R en/fwd.
  - SETTLE_T: motors off.
  - STEP: both en/fwd.
  - SETTLE_S: motors off.
  - DONE.
- Counter behaviour:
  - The counter is loaded with N-1 on state entry.
  - The state is exited on the edge where counter==0.
  - Each timed state therefore lasts exactly N cycles.
- Transitions:
  - IDLE + accept, valid non-zero code: -> TURN if delta!=0, else -> STEP.
  - IDLE + accept, 0000 or invalid code: -> DONE.
  - TURN expiry: heading <= heading+1 (right) or heading-1 (left), mod 4; -> SETTLE_T.
  - SETTLE_T expiry: -> TURN if turns remain, else -> STEP.
  - STEP expiry: -> SETTLE_S.
  - SETTLE_S expiry: -> DONE.
  - DONE lasts 1 cycle, then -> IDLE.
- Outputs:
  - Motor outputs are Moore-decoded from state and turn direction; they are 0 outside TURN/STEP.
  - busy = (state != IDLE).
  - done=1 only in DONE.
  - cmd_err=1 in DONE only when the accepted code was invalid.
  - Neither done nor cmd_err is raised on a stop abort.
- Stop:
  - stop=1 in TURN/SETTLE_T/STEP/SETTLE_S: next edge -> IDLE, motors off.
  - heading keeps only the 90-degree turns that completed; no done.
  - stop in IDLE or DONE has no effect.
  - stop takes priority over counter expiry on the same edge.
- Latency from accept, command cycles numbered 1.. after the accept edge: delta d (right turns, or 1 left) gives
  - d*(TURN90_CYCLES+SETTLE_CYCLES) + STEP_CYCLES + SETTLE_CYCLES cycles active,
  - then DONE,
  - then cmd_ready=1 on the following cycle.
- heading is only ever updated at TURN expiry.

Test Plan (TURN90_CYCLES=4, STEP_CYCLES=8, SETTLE_CYCLES=2):
- Reset, then cmd=0001 valid for 1 cycle -> L/R en=1 dir=1 cycles 1-8; motors off cycles 9-10; done=1 cycle 11; cmd_ready=1 cycle 12; heading=0.
- From heading 0, cmd=0011 -> cycles 1-4 L fwd/R rev; heading=1 from cycle 5; motors off cycles 5-6; step cycles 7-14; done cycle 17.
- From heading 1, cmd=0100 -> two right turns (cycles 1-4, 7-10); heading 2 then 3; done cycle 23. Then cmd=0010 -> one left turn (L rev/R fwd cycles 1-4); heading=2.
- cmd=0101 -> no motor activity; done=1 and cmd_err=1 in cycle 1, heading unchanged. Then cmd=0000 -> done=1, cmd_err=0.
- Abort cases:
  - stop=1 in STEP cycle 3 -> motors 0 next cycle, IDLE, no done.
  - rst asserted mid-TURN -> motors 0 immediately, heading=0.
- Back-to-back: cmd_valid held high with 0011 then 0001 -> second command accepted only in the cycle after the first done; no command is dropped or duplicated.

Source files
------------

// File: rtl/movement_executor.sv
// movement_executor: turns absolute-direction movement codes into timed differential-drive
// motor sequences (rotate to target heading, advance one cell) and tracks the heading.
module movement_executor #(
    parameter int TURN90_CYCLES = 1000,
    parameter int STEP_CYCLES   = 4000,
    parameter int SETTLE_CYCLES = 100,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       stop,
    output logic       motor_l_en,
    output logic       motor_l_dir,
    output logic       motor_r_en,
    output logic       motor_r_dir,
    output logic [1:0] heading,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);
    typedef enum logic [2:0] {IDLE, TURN, SETTLE_T, STEP, SETTLE_S, DONE} state_t;
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN90_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       heading_n, target, delta;
    logic             extra, extra_n;
    logic             left, left_n;
    logic             err, err_n;
    logic             code_ok, expire, timed;
    assign code_ok = cmd inside {4'b0001, 4'b0011, 4'b0010, 4'b0100};
    assign target  = cmd == 4'b0011 ? 2'd1 : cmd == 4'b0010 ? 2'd2 : cmd == 4'b0100 ? 2'd3 : 2'd0;
    assign delta   = target - heading;
    assign expire  = cnt == '0;
    assign timed   = state inside {TURN, SETTLE_T, STEP, SETTLE_S};
    // extra marks a second right turn still pending for a 180-degree rotation
    always_comb begin
        state_n   = state;
        cnt_n     = cnt - CNT_W'(1);
        heading_n = heading;
        extra_n   = extra;
        left_n    = left;
        err_n     = err;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (cmd_valid) begin
                    err_n   = !code_ok && cmd != 4'b0000;
                    left_n  = delta == 2'd3;
                    extra_n = delta == 2'd2;
                    state_n = !code_ok ? DONE : delta != 2'd0 ? TURN : STEP;
                    cnt_n   = !code_ok ? '0 : delta != 2'd0 ? TURN_LD : STEP_LD;
                end
            end
            TURN: if (expire) begin
                heading_n = left ? heading - 2'd1 : heading + 2'd1;
                state_n   = SETTLE_T;
                cnt_n     = SETTLE_LD;
            end
            SETTLE_T: if (expire) begin
                state_n = extra ? TURN : STEP;
                cnt_n   = extra ? TURN_LD : STEP_LD;
                extra_n = 1'b0;
            end
            STEP: if (expire) begin
                state_n = SETTLE_S;
                cnt_n   = SETTLE_LD;
            end
            SETTLE_S: if (expire) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // abort wins over expiry, so a turn cut short never reaches the heading
        if (stop && timed) begin
            state_n   = IDLE;
            cnt_n     = '0;
            heading_n = heading;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            heading     <= 2'd0;
            extra       <= 1'b0;
            left        <= 1'b0;
            err         <= 1'b0;
            motor_l_en  <= 1'b0;
            motor_l_dir <= 1'b0;
            motor_r_en  <= 1'b0;
            motor_r_dir <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            heading     <= heading_n;
            extra       <= extra_n;
            left        <= left_n;
            err         <= err_n;
            motor_l_en  <= state_n == TURN || state_n == STEP;
            motor_r_en  <= state_n == TURN || state_n == STEP;
            motor_l_dir <= state_n == STEP || (state_n == TURN && !left_n);
            motor_r_dir <= state_n == STEP || (state_n == TURN && left_n);
            busy        <= state_n != IDLE;
            done        <= state_n == DONE;
            cmd_err     <= state_n == DONE && err_n;
            cmd_ready   <= state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_movement_executor.sv
// tb_movement_executor: scoreboard bench; a reference model queues the expected per-cycle
// outputs for each command and the trace is compared cycle by cycle.
module tb_movement_executor;
    localparam int TURN = 4, STEP = 8, SETTLE = 2;
    typedef struct packed {
        logic [3:0] mot;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
        logic [1:0] head;
    } exp_t;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, stop = 1'b0;
    logic [3:0] cmd = 4'b0000;
    logic       cmd_ready, motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, busy, done, cmd_err;
    logic [1:0] heading;
    exp_t       obs;
    exp_t       q[$];
    logic [1:0] exp_head = 2'd0;
    int         n_checks = 0, n_fail = 0;

    movement_executor #(.TURN90_CYCLES(TURN), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .stop(stop),
        .motor_l_en(motor_l_en), .motor_l_dir(motor_l_dir), .motor_r_en(motor_r_en),
        .motor_r_dir(motor_r_dir), .heading(heading), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;
    assign obs = {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, busy, done, cmd_err, cmd_ready, heading};

    task automatic add(input logic [3:0] m, input logic dn, input logic er, input int n);
        for (int i = 0; i < n; i++) q.push_back('{m, 1'b1, dn, er, 1'b0, exp_head});
    endtask

    // reference model: motor vector is {l_en, l_dir, r_en, r_dir}
    task automatic model(input logic [3:0] c);
        logic [1:0] t, d;
        logic       ok;
        ok = 1'b1;
        t  = 2'd0;
        case (c)
            4'b0001: t = 2'd0;
            4'b0011: t = 2'd1;
            4'b0010: t = 2'd2;
            4'b0100: t = 2'd3;
            default: ok = 1'b0;
        endcase
        if (!ok) add(4'b0000, 1'b1, c != 4'b0000, 1);
        else begin
            d = t - exp_head;
            if (d == 2'd3) begin
                add(4'b1011, 1'b0, 1'b0, TURN);
                exp_head = exp_head - 2'd1;
                add(4'b0000, 1'b0, 1'b0, SETTLE);
            end else begin
                for (int i = 0; i < int'(d); i++) begin
                    add(4'b1110, 1'b0, 1'b0, TURN);
                    exp_head = exp_head + 2'd1;
                    add(4'b0000, 1'b0, 1'b0, SETTLE);
                end
            end
            add(4'b1111, 1'b0, 1'b0, STEP);
            add(4'b0000, 1'b0, 1'b0, SETTLE);
            add(4'b0000, 1'b1, 1'b0, 1);
        end
    endtask

    task automatic drain(input string nm, input int stop_at, input int drop_at);
        exp_t e;
        int   k;
        k = 1;
        while (q.size() > 0) begin
            if (k == drop_at) cmd_valid = 1'b0;
            e = q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b, expected %b", nm, k, obs, e);
            end
            if (k == stop_at) stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            k++;
        end
        n_checks++;
        if ({busy, cmd_ready, done, cmd_err} !== 4'b0100) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy/ready/done/err %b, expected 0100", nm, {busy, cmd_ready, done, cmd_err});
        end
    endtask

    task automatic run_cmd(input string nm, input logic [3:0] c, input int stop_at);
        logic [1:0] h;
        model(c);
        if (stop_at > 0 && stop_at < q.size()) begin
            h = q[stop_at-1].head;
            while (q.size() > stop_at) void'(q.pop_back());
            q.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, h});
            exp_head = h;
        end
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        drain(nm, stop_at, 0);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, expected 0000000100", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_release: got %b, expected 0000000100", obs);
        end
    endtask

    task automatic test_turns;
        run_cmd("forward", 4'b0001, 0);
        run_cmd("right", 4'b0011, 0);
        n_checks++;
        if (heading !== 2'd1) begin
            n_fail++;
            $display("FAIL right_heading: got %0d, expected 1", heading);
        end
        run_cmd("two_right", 4'b0100, 0);
        run_cmd("left", 4'b0010, 0);
        n_checks++;
        if (heading !== 2'd2) begin
            n_fail++;
            $display("FAIL left_heading: got %0d, expected 2", heading);
        end
    endtask

    task automatic test_invalid;
        run_cmd("invalid_0101", 4'b0101, 0);
        run_cmd("noop_0000", 4'b0000, 0);
        run_cmd("invalid_1111_stop_in_done", 4'b1111, 1);
        run_cmd("invalid_1000", 4'b1000, 0);
    endtask

    task automatic test_stop;
        run_cmd("stop_step", 4'b0010, 3);
        run_cmd("stop_left_turn", 4'b0011, 2);
        run_cmd("stop_second_turn", 4'b0001, 7);
        run_cmd("stop_at_turn_expiry", 4'b0001, 4);
        n_checks++;
        if (heading !== 2'd3) begin
            n_fail++;
            $display("FAIL stop_heading: got %0d, expected 3", heading);
        end
    endtask

    task automatic test_reset_mid_turn;
        @(negedge clk);
        cmd = 4'b0001;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs.mot !== 4'b1110) begin
            n_fail++;
            $display("FAIL rst_pre_turn: got %b, expected 1110", obs.mot);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_turn: got %b, expected 0000000100", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_head = 2'd0;
    endtask

    task automatic test_back_to_back;
        int len1;
        model(4'b0011);
        len1 = q.size();
        q.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, exp_head});
        model(4'b0001);
        @(negedge clk);
        cmd = 4'b0011;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd = 4'b0001;
        drain("back_to_back", 0, len1 + 2);
        n_checks++;
        if (heading !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_heading: got %0d, expected 0", heading);
        end
    endtask

    task automatic test_random;
        logic [3:0] c;
        for (int i = 0; i < 8; i++) begin
            c = 4'($urandom_range(0, 15));
            run_cmd($sformatf("random_%0d_code_%b", i, c), c, 0);
        end
    endtask

    initial begin
        test_reset;
        test_turns;
        test_invalid;
        test_stop;
        test_reset_mid_turn;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
